// File: rtl/hs32_xbus_pkg.sv
// hs32_xbus_pkg: shared definitions for the hs32 external byte-bus adapter.
//   state_t   : adapter FSM state encoding
//   BEATS     : byte beats per 32-bit word
//   WAITW     : width of the wait-state counter
//   byte_lane : little-endian byte extraction from a 32-bit word
package hs32_xbus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int BEATS = 4;
    localparam int WAITW = 4;

    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/hs32_waitcnt.sv
// hs32_waitcnt: loadable down-counter that times the strobe phase of a beat.
//   clk, rstn : clock, asynchronous active-low reset (count resets to 0)
//   load      : load ld_val (has priority over en)
//   en        : decrement by one, holding at zero
//   ld_val    : value loaded on load
//   zero      : count is zero
module hs32_waitcnt
    import hs32_xbus_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             en,
    input  logic [WAITW-1:0] ld_val,
    output logic             zero
);

    logic [WAITW-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= ld_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hs32_xbus.sv
// hs32_xbus: serialises one 32-bit arbiter request into four 8-bit
// SRAM-style beats (little-endian, byte address base+k carries bits
// [8k+7:8k]) with WAIT_CYCLES extra strobe cycles per beat.
//   clk, rstn          : clock, asynchronous active-low reset
//   addr, rw, dout     : arbiter request (latched on acceptance), addr[1:0] ignored
//   valid              : request present
//   din                : last completed read word
//   ready              : one-cycle completion pulse
//   xaddr              : external byte address
//   xdata_o, xdata_oe  : external write byte and its drive enable
//   xdata_i            : external read byte
//   xcs_n, xoe_n, xwe_n: active-low chip select, output enable, write strobe
// All outputs are registered; every output change is made on the state
// transition that enters the state in which the value must be visible.
module hs32_xbus
    import hs32_xbus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] addr,
    input  logic        rw,
    input  logic [31:0] dout,
    output logic [31:0] din,
    input  logic        valid,
    output logic        ready,
    output logic [31:0] xaddr,
    output logic [7:0]  xdata_o,
    input  logic [7:0]  xdata_i,
    output logic        xdata_oe,
    output logic        xcs_n,
    output logic        xoe_n,
    output logic        xwe_n
);

    localparam logic [WAITW-1:0] WAIT_LD   = WAIT_CYCLES[WAITW-1:0];
    localparam logic [1:0]       LAST_BEAT = 2'(BEATS - 1);

    state_t      state;
    logic [1:0]  beat;
    logic [29:0] abase;
    logic        wr;
    logic [31:0] wdata;
    logic [23:0] rbuf;    // lanes 0..2; lane 3 goes straight into din
    logic        cnt_zero;

    // Word-aligned bus: the byte offset bits of the request are meaningless.
    logic addr_lsb_unused;
    assign addr_lsb_unused = ^addr[1:0];

    // Counter is loaded during SETUP so STROBE sees WAIT_CYCLES..0.
    hs32_waitcnt u_waitcnt (
        .clk    (clk),
        .rstn   (rstn),
        .load   (state == SETUP),
        .en     (state == STROBE),
        .ld_val (WAIT_LD),
        .zero   (cnt_zero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            beat     <= 2'd0;
            abase    <= '0;
            wr       <= 1'b0;
            wdata    <= '0;
            rbuf     <= '0;
            ready    <= 1'b0;
            din      <= '0;
            xaddr    <= '0;
            xdata_o  <= '0;
            xdata_oe <= 1'b0;
            xcs_n    <= 1'b1;
            xoe_n    <= 1'b1;
            xwe_n    <= 1'b1;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        abase <= addr[31:2];
                        wr    <= rw;
                        wdata <= dout;
                        beat  <= 2'd0;
                        // Beat 0 bus fields come from the live inputs
                        // since the latches are only being written now.
                        xaddr <= {addr[31:2], 2'b00};
                        xcs_n <= 1'b0;
                        if (rw) begin
                            xdata_o  <= dout[7:0];
                            xdata_oe <= 1'b1;
                        end else begin
                            xoe_n <= 1'b0;
                        end
                        state <= SETUP;
                    end
                end

                SETUP: begin
                    if (wr) begin
                        xwe_n <= 1'b0;
                    end
                    state <= STROBE;
                end

                STROBE: begin
                    if (cnt_zero) begin
                        xwe_n <= 1'b1;
                        if (!wr) begin
                            case (beat)
                                2'd0:    rbuf[7:0]   <= xdata_i;
                                2'd1:    rbuf[15:8]  <= xdata_i;
                                2'd2:    rbuf[23:16] <= xdata_i;
                                default: ;
                            endcase
                        end
                        if (beat == LAST_BEAT) begin
                            ready    <= 1'b1;
                            xcs_n    <= 1'b1;
                            xoe_n    <= 1'b1;
                            xdata_oe <= 1'b0;
                            if (!wr) begin
                                din <= {xdata_i, rbuf};
                            end
                            state <= DONE;
                        end else begin
                            // A read keeps xoe_n low straight into the next
                            // SETUP, so there is no visible release between beats.
                            beat  <= beat + 2'd1;
                            xaddr <= {abase, beat + 2'd1};
                            if (wr) begin
                                xdata_o <= byte_lane(wdata, beat + 2'd1);
                            end
                            state <= SETUP;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs32_xbus.sv
// Scoreboard bench for hs32_xbus: instance 0 runs WAIT_CYCLES=1, instance 1
// runs WAIT_CYCLES=0. Each side sees a byte-wide SRAM model; the reference
// model keeps its own shadow copy of memory and predicts, per transaction,
// the ready cycle, din, the byte address sequence and the written bytes.
module tb_hs32_xbus;

    logic        clk = 1'b0;
    logic        rstn;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    logic [31:0] addr_s  [2];
    logic [31:0] dout_s  [2];
    logic        rw_s    [2];
    logic        valid_s [2];
    logic [31:0] din_w   [2];
    logic        ready_w [2];
    logic [31:0] xaddr_w [2];
    logic [7:0]  xdo_w   [2];
    logic [7:0]  xdi_w   [2];
    logic        xoe_w   [2];
    logic        xcs_w   [2];
    logic        xoen_w  [2];
    logic        xwen_w  [2];

    logic [7:0]  ext_mem [2][65536];
    logic        mem_init = 1'b0;
    logic [7:0]  shadow  [2][65536];
    logic [31:0] last_din [2];

    typedef struct {
        int          g;
        bit          rw;
        logic [31:0] base;
        logic [31:0] wdata;
        logic [31:0] din;
        int          cyc;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] obs_a[$];
    logic [7:0]  obs_d[$];

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        hs32_xbus #(.WAIT_CYCLES(g == 0 ? 1 : 0)) u_dut (
            .clk      (clk),
            .rstn     (rstn),
            .addr     (addr_s[g]),
            .rw       (rw_s[g]),
            .dout     (dout_s[g]),
            .din      (din_w[g]),
            .valid    (valid_s[g]),
            .ready    (ready_w[g]),
            .xaddr    (xaddr_w[g]),
            .xdata_o  (xdo_w[g]),
            .xdata_i  (xdi_w[g]),
            .xdata_oe (xoe_w[g]),
            .xcs_n    (xcs_w[g]),
            .xoe_n    (xoen_w[g]),
            .xwe_n    (xwen_w[g])
        );
        // SRAM drives the bus only while selected with output enable low.
        assign xdi_w[g] = (!xcs_w[g] && !xoen_w[g]) ? ext_mem[g][xaddr_w[g][15:0]] : 8'h00;
    end

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        case (a)
            16'h1004: return 8'h11;
            16'h1005: return 8'h22;
            16'h1006: return 8'h33;
            16'h1007: return 8'h44;
            default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int g = 0; g < 2; g++)
                for (int i = 0; i < 65536; i++)
                    ext_mem[g][i] <= init_byte(16'(i));
            mem_init <= 1'b1;
        end else begin
            for (int g = 0; g < 2; g++)
                if (!xcs_w[g] && !xwen_w[g])
                    ext_mem[g][xaddr_w[g][15:0]] <= xdo_w[g];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if (a[15:12] == 4'hF) a[15:12] = 4'h7;   // 0xF000 page is left to the abort test
        return a;
    endfunction

    function automatic int latency(input int g);
        return 4 * ((g == 0 ? 1 : 0) + 2) + 1;
    endfunction

    // Reference model: applies the transaction to the shadow memory and
    // queues what the bus and arbiter side must show for it.
    task automatic push_exp(input int g, input bit rw, input logic [31:0] a,
                            input logic [31:0] d, input int when);
        txn_t t;
        logic [31:0] ba;
        t.g     = g;
        t.rw    = rw;
        t.base  = {a[31:2], 2'b00};
        t.wdata = d;
        t.cyc   = when;
        t.din   = '0;
        for (int k = 0; k < 4; k++) begin
            ba = t.base + 32'(k);
            if (rw) shadow[g][ba[15:0]] = d[8*k +: 8];
            else    t.din[8*k +: 8] = shadow[g][ba[15:0]];
        end
        if (rw) t.din = last_din[g];
        else    last_din[g] = t.din;
        exp_q.push_back(t);
    endtask

    task automatic drive(input int g, input bit v, input bit rw, input logic [31:0] a, input logic [31:0] d);
        valid_s[g] = v;
        rw_s[g]    = rw;
        addr_s[g]  = a;
        dout_s[g]  = d;
    endtask

    // Called at a negedge in an IDLE cycle; returns at the negedge of the
    // next IDLE cycle. mode 0: valid for one cycle; 1: inputs churn after
    // acceptance; 2: valid held past beat 1, then dropped.
    task automatic run_txn(input int g, input bit rw, input logic [31:0] a, input logic [31:0] d, input int mode);
        int c0, lat, drop;
        lat  = latency(g);
        c0   = cyc;
        drop = (mode == 2) ? c0 + 2 * ((g == 0 ? 1 : 0) + 2) + 1 : c0 + 1;
        drive(g, 1'b1, rw, a, d);
        push_exp(g, rw, a, d, c0 + lat);
        while (cyc != c0 + lat + 1) begin
            @(negedge clk);
            if (mode == 1) begin
                addr_s[g] = $urandom;
                dout_s[g] = $urandom;
                rw_s[g]   = 1'($urandom_range(0, 1));
            end
            if (cyc == drop) valid_s[g] = 1'b0;
        end
    endtask

    // Write followed by a read with valid held high throughout.
    task automatic b2b(input int g, input logic [31:0] a1, input logic [31:0] d1, input logic [31:0] a2);
        int c0, c1, lat;
        lat = latency(g);
        c0  = cyc;
        c1  = c0 + lat + 1;
        drive(g, 1'b1, 1'b1, a1, d1);
        push_exp(g, 1'b1, a1, d1, c0 + lat);
        push_exp(g, 1'b0, a2, 32'h0, c1 + lat);
        @(negedge clk);
        rw_s[g]   = 1'b0;
        addr_s[g] = a2;
        dout_s[g] = $urandom;
        while (cyc != c1 + 1) @(negedge clk);
        valid_s[g] = 1'b0;
        while (cyc != c1 + lat + 1) @(negedge clk);
    endtask

    task automatic check_done(input int g);
        txn_t t;
        if (exp_q.size() == 0 || exp_q[0].g != g) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected ready: dut %0d got 1, want 0 (cycle %0d)", g, cyc);
        end else begin
            t = exp_q.pop_front();
            chk("ready cycle", 32'(cyc), 32'(t.cyc));
            chk("din", din_w[g], t.din);
            chk("beat count", 32'(obs_a.size()), 32'd4);
            for (int k = 0; k < obs_a.size() && k < 4; k++)
                chk("xaddr beat", obs_a[k], t.base + 32'(k));
            if (t.rw) begin
                chk("write byte count", 32'(obs_d.size()), 32'd4);
                for (int k = 0; k < obs_d.size() && k < 4; k++)
                    chk("write byte", 32'(obs_d[k]), 32'(t.wdata[8*k +: 8]));
            end else begin
                chk("read strobes xwe_n", 32'(obs_d.size()), 32'd0);
            end
        end
        obs_a.delete();
        obs_d.delete();
    endtask

    // Bus / completion monitor.
    initial begin
        logic        prev_cs [2];
        logic        prev_we [2];
        logic [31:0] prev_a  [2];
        int          we_run  [2];
        for (int g = 0; g < 2; g++) begin
            prev_cs[g] = 1'b1;
            prev_we[g] = 1'b1;
            prev_a[g]  = '0;
            we_run[g]  = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (!rstn) begin
                    prev_cs[g] = 1'b1;
                    prev_we[g] = 1'b1;
                    we_run[g]  = 0;
                    obs_a.delete();
                    obs_d.delete();
                end else begin
                    if (!xcs_w[g] && (prev_cs[g] || xaddr_w[g] != prev_a[g]))
                        obs_a.push_back(xaddr_w[g]);
                    if (!xwen_w[g]) begin
                        if (prev_we[g]) begin
                            we_run[g] = 1;
                            if (xoe_w[g]) obs_d.push_back(xdo_w[g]);
                        end else begin
                            we_run[g]++;
                        end
                    end else if (!prev_we[g]) begin
                        chk("xwe_n low cycles", 32'(we_run[g]), (g == 0) ? 32'd2 : 32'd1);
                    end
                    prev_cs[g] = xcs_w[g];
                    prev_we[g] = xwen_w[g];
                    prev_a[g]  = xaddr_w[g];
                    if (ready_w[g]) begin
                        check_done(g);
                    end else if (exp_q.size() > 0 && exp_q[0].g == g && cyc > exp_q[0].cyc) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL ready missing: dut %0d got 0, want 1 at cycle %0d", g, exp_q[0].cyc);
                        void'(exp_q.pop_front());
                        obs_a.delete();
                        obs_d.delete();
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pool [4];
        logic [31:0] a;
        int          cs_low;
        int          c0;

        rstn = 1'b1;
        for (int g = 0; g < 2; g++) begin
            drive(g, 1'b0, 1'b0, 32'h0, 32'h0);
            last_din[g] = '0;
            for (int i = 0; i < 65536; i++) shadow[g][i] = init_byte(16'(i));
        end
        for (int i = 0; i < 4; i++) pool[i] = rand_addr();

        #1 rstn = 1'b0;
        #2;
        for (int g = 0; g < 2; g++) begin
            chk("reset din",      din_w[g],          32'h0);
            chk("reset xaddr",    xaddr_w[g],        32'h0);
            chk("reset xdata_o",  32'(xdo_w[g]),     32'h0);
            chk("reset xdata_oe", 32'(xoe_w[g]),     32'h0);
            chk("reset xcs_n",    32'(xcs_w[g]),     32'h1);
            chk("reset xoe_n",    32'(xoen_w[g]),    32'h1);
            chk("reset xwe_n",    32'(xwen_w[g]),    32'h1);
            chk("reset ready",    32'(ready_w[g]),   32'h0);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // WAIT_CYCLES = 1: directed read, write, read-back
        run_txn(0, 1'b0, 32'h0000_1007, 32'h0, 0);
        chk("directed read din", din_w[0], 32'h4433_2211);
        run_txn(0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 0);
        chk("din kept after write", din_w[0], 32'h4433_2211);
        run_txn(0, 1'b0, 32'h0000_2000, 32'h0, 0);
        chk("read-back din", din_w[0], 32'hDEAD_BEEF);

        // input churn after acceptance, then premature valid drop
        a = rand_addr();
        run_txn(0, 1'b1, a, $urandom, 1);
        run_txn(0, 1'b0, a, $urandom, 1);
        run_txn(0, 1'b0, a, 32'h0, 2);
        run_txn(0, 1'b1, rand_addr(), $urandom, 2);

        repeat (20) begin
            run_txn(0, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)], $urandom, $urandom_range(0, 2));
        end

        // reset in the middle of the beat-2 strobe of a write
        c0 = cyc;
        drive(0, 1'b1, 1'b1, 32'h0000_F000, $urandom);
        @(negedge clk);
        valid_s[0] = 1'b0;
        while (cyc != c0 + 8) @(negedge clk);
        chk("abort pre xwe_n", 32'(xwen_w[0]), 32'h0);
        chk("abort pre xaddr", xaddr_w[0], 32'h0000_F002);
        #2 rstn = 1'b0;
        #1;
        chk("abort xcs_n",    32'(xcs_w[0]),  32'h1);
        chk("abort xwe_n",    32'(xwen_w[0]), 32'h1);
        chk("abort xoe_n",    32'(xoen_w[0]), 32'h1);
        chk("abort xdata_oe", 32'(xoe_w[0]),  32'h0);
        chk("abort ready",    32'(ready_w[0]), 32'h0);
        chk("abort din",      din_w[0],       32'h0);
        last_din[0] = '0;
        last_din[1] = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        cs_low = 0;
        repeat (20) begin
            @(negedge clk);
            if (!xcs_w[0]) cs_low++;
        end
        chk("abort no further beats", 32'(cs_low), 32'h0);
        run_txn(0, 1'b0, 32'h0000_1004, 32'h0, 0);

        // WAIT_CYCLES = 0: back-to-back and random traffic
        b2b(1, 32'h0000_3000, 32'hCAFE_F00D, 32'h0000_3000);
        chk("b2b read din", din_w[1], 32'hCAFE_F00D);
        repeat (12) begin
            if ($urandom_range(0, 2) == 0)
                b2b(1, pool[$urandom_range(0, 3)], $urandom, pool[$urandom_range(0, 3)]);
            else
                run_txn(1, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)], $urandom, $urandom_range(0, 2));
        end

        repeat (10) @(negedge clk);
        chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hs32_xbus.md
Name: hs32_xbus

Overview:
- External byte-wide bus adapter that sits directly downstream of the internal memory arbiter.
- Accepts the arbiter's 32-bit addr/rw/dout/valid request and serialises it into four 8-bit SRAM-style beats with programmable wait states.
- Returns assembled read data on din and pulses ready when the whole word is complete.

Parameters:
- WAIT_CYCLES, 1: extra strobe cycles per beat; legal range 0..15.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- addr  in  32  word address from arbiter; bits [1:0] ignored
- rw  in  1  1 = write, 0 = read
- dout  in  32  write data from arbiter
- din  out  32  read data to arbiter
- valid  in  1  request present
- ready  out  1  one-cycle pulse, transaction complete
- xaddr  out  32  external byte address
- xdata_o  out  8  external write byte
- xdata_i  in  8  external read byte
- xdata_oe  out  1  drive enable for xdata_o
- xcs_n  out  1  chip select, active low
- xoe_n  out  1  output enable (read), active low
- xwe_n  out  1  write strobe, active low

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; ready = 0; din = 0; xaddr = 0; xdata_o = 0; xdata_oe = 0.
  - xcs_n, xoe_n and xwe_n are all 1.
  - Reset mid-transaction aborts it immediately: strobes release asynchronously, no ready pulse is issued.
- All external outputs, ready and din are registered (no combinational path from inputs).
- FSM states: IDLE, SETUP, STROBE, DONE.
- IDLE:
  - When valid = 1, latch addr[31:2], rw and dout; set beat = 0; go to SETUP.
  - When valid = 0, stay in IDLE.
- SETUP (1 cycle):
  - xaddr = {addr[31:2], beat[1:0]}; xcs_n = 0.
  - Read: xoe_n = 0.
  - Write: xdata_o = dout[8*beat+7 : 8*beat]; xdata_oe = 1.
  - Load wait counter with WAIT_CYCLES; go to STROBE.
- STROBE (WAIT_CYCLES+1 cycles):
  - Write: xwe_n = 0. Read: xoe_n stays 0.
  - Counter decrements each cycle. When counter = 0:
    - Read: sample xdata_i into read-buffer byte lane [beat]. Write: nothing is sampled.
    - Deassert xwe_n and xoe_n.
    - beat = 3: go to DONE. Otherwise: beat + 1, go to SETUP.
- Per-beat bus fields:
  - xcs_n stays 0 across SETUP/STROBE of all four beats.
  - xdata_oe stays 1 for the whole write transaction.
- Little-endian lane order: beat k carries bits [8k+7:8k] at byte address base + k.
- DONE (1 cycle):
  - ready = 1; xcs_n = 1; xdata_oe = 0.
  - Read: din is updated with the assembled word in this same cycle.
  - Go to IDLE.
- din holds the last completed read word; writes never modify din.
- Latency: valid sampled in IDLE at cycle 0 → ready high at cycle 4*(WAIT_CYCLES+2)+1. For WAIT_CYCLES = 1 this is cycle 13.
- Handshake contract:
  - Arbiter-side inputs are latched at acceptance; later changes to addr, rw and dout are ignored.
  - valid still high in the IDLE cycle after DONE is a new back-to-back transaction. The minimum gap is one IDLE cycle.
  - valid dropping mid-transaction is a protocol violation. The block still completes all beats and pulses ready; the arbiter gates that pulse.
- WAIT_CYCLES = 0: STROBE lasts exactly 1 cycle per beat.

Decomposition:
- Package hs32_xbus_pkg holds:
  - state encoding: IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, DONE = 2'd3;
  - BEATS = 4;
  - WAITW = 4 (wait-counter width).
- One sub-module, hs32_waitcnt: loadable 4-bit down-counter with load, enable and zero flag, reset to 0. Everything else stays in hs32_xbus.

Test Plan:
- Reset: assert rstn = 0 mid-STROBE of beat 2 → xcs_n, xwe_n and xoe_n go to 1 asynchronously, ready = 0, state = IDLE, no further beats.
- Read, WAIT_CYCLES = 1: addr = 0x0000_1007, memory bytes at 0x1004..0x1007 = 0x11, 0x22, 0x33, 0x44 →
  - xaddr sequence 0x1004, 0x1005, 0x1006, 0x1007;
  - ready pulses once, 13 cycles after acceptance;
  - din = 0x4433_2211.
- Write, WAIT_CYCLES = 1: addr = 0x2000, dout = 0xDEAD_BEEF →
  - bytes 0xEF, 0xBE, 0xAD, 0xDE are written to 0x2000..0x2003;
  - xwe_n is low for exactly 2 cycles per beat;
  - din is unchanged.
- Back-to-back, WAIT_CYCLES = 0: write then read held on valid with no gap →
  - second transaction accepted in the IDLE cycle right after the first ready;
  - each ready arrives 9 cycles after its acceptance.
- Input churn: change addr and dout on every cycle after acceptance → bus shows only the originally latched values.
- Premature valid drop after beat 1 → all 4 beats still complete and ready pulses at the nominal cycle.
